tone_period_decoder: RTL and testbench



---
 rtl/tone_period_decoder.sv | 145 ++++++++++++++
 tb/tb_tone_period_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_period_decoder.sv
// Measures the period of a square-wave tone in clk ticks, locks onto stable notes,
// and reports note start/end pulses plus the note duration in milliseconds.
module tone_period_decoder #(
  parameter int PERIOD_W   = 16,
  parameter int TOL        = 2,
  parameter int SILENCE_MS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tone_in,
  input  logic [15:0]         ticks_per_milli,
  output logic [PERIOD_W-1:0] period,
  output logic                locked,
  output logic                note_start,
  output logic                note_end,
  output logic [15:0]         dur_ms,
  output logic                silence
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKING, LOCKED} state_t;

  localparam int                  SIL_W   = $clog2(SILENCE_MS + 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W:0]   MEAS_ONE = (PERIOD_W+1)'(1);
  localparam logic [PERIOD_W:0]   TOL_V   = (PERIOD_W+1)'(TOL);
  localparam logic [SIL_W-1:0]    SIL_LIM = SIL_W'(SILENCE_MS);
  localparam logic [SIL_W-1:0]    SIL_ONE = SIL_W'(1);

  state_t              state, state_nxt;
  logic                sync0, sync1, sync2;
  logic                rise, overflow, ms_tick, timeout;
  logic [PERIOD_W-1:0] cnt, cand, cand_nxt, period_nxt;
  logic [PERIOD_W:0]   meas, diff_cand, diff_period;
  logic [15:0]         pre, tpm_eff, dur_nxt;
  logic [SIL_W-1:0]    sil_cnt;
  logic                start_nxt, end_nxt;

  function automatic logic [PERIOD_W:0] abs_diff(input logic [PERIOD_W:0] a,
                                                  input logic [PERIOD_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign rise        = sync1 & ~sync2;
  assign overflow    = (cnt == CNT_MAX);
  assign meas        = {1'b0, cnt} + MEAS_ONE;
  assign diff_cand   = abs_diff(meas, {1'b0, cand});
  assign diff_period = abs_diff(meas, {1'b0, period});
  assign tpm_eff     = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  // >= rather than == so a mid-count shrink of ticks_per_milli wraps at once
  assign ms_tick     = (pre >= tpm_eff - 16'd1);
  assign timeout     = (sil_cnt == SIL_LIM) & ~rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      pre        <= '0;
      sil_cnt    <= '0;
      state      <= IDLE;
      cand       <= '0;
      period     <= '0;
      locked     <= 1'b0;
      note_start <= 1'b0;
      note_end   <= 1'b0;
      dur_ms     <= '0;
      silence    <= 1'b1;
    end else begin
      sync0 <= tone_in;
      sync1 <= sync0;
      sync2 <= sync1;

      if (rise)           cnt <= '0;
      else if (!overflow) cnt <= cnt + CNT_ONE;

      if (ms_tick) pre <= '0;
      else         pre <= pre + 16'd1;

      if (rise)                               sil_cnt <= '0;
      else if (ms_tick && sil_cnt != SIL_LIM) sil_cnt <= sil_cnt + SIL_ONE;

      state      <= state_nxt;
      cand       <= cand_nxt;
      period     <= period_nxt;
      locked     <= (state_nxt == LOCKED);
      note_start <= start_nxt;
      note_end   <= end_nxt;
      dur_ms     <= dur_nxt;
      silence    <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    period_nxt = period;
    start_nxt  = 1'b0;
    end_nxt    = 1'b0;
    dur_nxt    = dur_ms;

    if (state == LOCKED && ms_tick && dur_ms != 16'hFFFF) dur_nxt = dur_ms + 16'd1;

    // A rise always takes priority over a simultaneous silence timeout
    if (rise) begin
      case (state)
        IDLE: state_nxt = ARMED;
        ARMED: begin
          if (!overflow) begin
            cand_nxt  = meas[PERIOD_W-1:0];
            state_nxt = LOCKING;
          end
        end
        LOCKING: begin
          if (overflow) begin
            state_nxt = ARMED;
          end else if (diff_cand <= TOL_V) begin
            state_nxt  = LOCKED;
            period_nxt = meas[PERIOD_W-1:0];
            start_nxt  = 1'b1;
            dur_nxt    = '0;
          end else begin
            cand_nxt = meas[PERIOD_W-1:0];
          end
        end
        LOCKED: begin
          if (overflow) begin
            state_nxt = ARMED;
            end_nxt   = 1'b1;
          end else if (diff_period <= TOL_V) begin
            period_nxt = meas[PERIOD_W-1:0];
          end else begin
            state_nxt = LOCKING;
            cand_nxt  = meas[PERIOD_W-1:0];
            end_nxt   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout && state != IDLE) begin
      state_nxt = IDLE;
      if (state == LOCKED) end_nxt = 1'b1;
    end
  end
endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed-stimulus bench for tone_period_decoder with an edge-time based reference model.
module tb_tone_period_decoder;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tone_in = 1'b0;
  logic [15:0]   tpm = 16'd100;
  logic [PW-1:0] period;
  logic          locked, note_start, note_end, silence;
  logic [15:0]   dur_ms;

  tone_period_decoder #(.PERIOD_W(PW), .TOL(2), .SILENCE_MS(20)) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .ticks_per_milli(tpm),
    .period(period), .locked(locked), .note_start(note_start),
    .note_end(note_end), .dur_ms(dur_ms), .silence(silence)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  // Reference model: decisions made from absolute edge numbers of rises and ms ticks
  bit     mvalid = 0;
  longint r_edge = 0, last_rise = 0;
  bit     hist[$];
  int     m_state = 0;  // 0 idle, 1 armed, 2 locking, 3 locked
  longint m_cand = 0, m_period = 0, m_dur = 0;
  bit     m_locked = 0, m_start = 0, m_end = 0, m_sil = 1;

  function automatic bit samp(int k);
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  // Number of ms ticks at edges in (a, b]; ticks land every tp edges after the reset edge
  function automatic longint ticks_in(longint a, longint b, longint tp);
    return (b - r_edge) / tp - (a - r_edge) / tp;
  endfunction

  function automatic longint absd(longint a, longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge clk) begin
    longint e, tp, meas;
    bit     rz, tick, tout, ok;
    cyc = cyc + 1;
    e = cyc;
    if (!rst_n) begin
      mvalid = 1; r_edge = e; last_rise = e; hist.delete();
      m_state = 0; m_cand = 0; m_period = 0; m_dur = 0;
      m_locked = 0; m_start = 0; m_end = 0; m_sil = 1;
    end else begin
      tp = (tpm == 16'd0) ? 1 : longint'(tpm);
      hist.push_back(tone_in);
      if (hist.size() > 4) void'(hist.pop_front());
      rz   = samp(2) && !samp(3);
      tick = ((e - r_edge) % tp) == 0;
      tout = !rz && (ticks_in(last_rise, e - 1, tp) >= 20);
      meas = e - last_rise;
      ok   = (meas <= 65535);
      m_start = 0; m_end = 0;
      if (m_state == 3 && tick && m_dur < 65535) m_dur = m_dur + 1;
      if (rz) begin
        last_rise = e;
        if (m_state == 0) m_state = 1;
        else if (!ok) begin
          if (m_state == 3) m_end = 1;
          m_state = 1;
        end else if (m_state == 1) begin
          m_cand = meas; m_state = 2;
        end else if (m_state == 2) begin
          if (absd(meas, m_cand) <= 2) begin
            m_state = 3; m_period = meas; m_start = 1; m_dur = 0;
          end else m_cand = meas;
        end else begin
          if (absd(meas, m_period) <= 2) m_period = meas;
          else begin
            m_end = 1; m_cand = meas; m_state = 2;
          end
        end
      end else if (tout && m_state != 0) begin
        if (m_state == 3) m_end = 1;
        m_state = 0;
      end
      m_locked = (m_state == 3);
      m_sil    = (m_state == 0);
    end
  end

  // Pulse monitor and per-cycle compare against the model
  int     n_start = 0, n_end = 0;
  longint start_cyc = 0, end_cyc = 0, start_per = 0, end_dur = 0;

  always @(negedge clk) begin
    if (note_start) begin n_start++; start_cyc = cyc; start_per = period; end
    if (note_end)   begin n_end++;   end_cyc = cyc;   end_dur = dur_ms;   end
    if (mvalid) begin
      checks++;
      if (period !== PW'(m_period) || locked !== m_locked || note_start !== m_start ||
          note_end !== m_end || dur_ms !== 16'(m_dur) || silence !== m_sil) begin
        errors++;
        $display("FAIL model cyc=%0d got p=%0d l=%0b s=%0b e=%0b d=%0d sil=%0b want p=%0d l=%0b s=%0b e=%0b d=%0d sil=%0b",
                 cyc, period, locked, note_start, note_end, dur_ms, silence,
                 m_period, m_locked, m_start, m_end, m_dur, m_sil);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d want=[%0d..%0d]", name, got, lo, hi);
    end
  endtask

  longint last_set = 0;
  task automatic tone_cycle(input int hi, input int lo);
    tone_in = 1'b1;
    last_set = cyc;
    repeat (hi) @(negedge clk);
    tone_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_reset(input logic [15:0] new_tpm);
    rst_n = 1'b0;
    tpm = new_tpm;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input int base, input int maxc);
    for (int i = 0; i < maxc && n_end == base; i++) @(negedge clk);
  endtask

  initial begin
    int     bs, be;
    longint d0;
    @(negedge clk);
    // Reset held with the tone toggling
    rst_n = 1'b0; tpm = 16'd100;
    tone_in = 1'b1; @(negedge clk);
    tone_in = 1'b0; @(negedge clk);
    tone_in = 1'b0; rst_n = 1'b1;
    check("rst_silence", silence, 1, 1);
    check("rst_locked", locked, 0, 0);
    check("rst_period", period, 0, 0);
    check("rst_dur", dur_ms, 0, 0);
    check("rst_pulses", n_start + n_end, 0, 0);
    repeat (5) @(negedge clk);

    // Lock on a 40-clk tone
    tone_cycle(20, 20); tone_cycle(20, 20);
    check("prelock_start", n_start, 0, 0);
    tone_cycle(20, 20);
    check("start_count", n_start, 1, 1);
    check("start_latency", start_cyc - last_set, 3, 3);
    check("start_period", start_per, 40, 40);
    check("locked_40", locked, 1, 1);
    check("silence_off", silence, 0, 0);

    // Jitter inside tolerance, then a jump to 45
    tone_cycle(21, 20); tone_cycle(20, 19); tone_cycle(20, 20);
    tone_cycle(21, 21); tone_cycle(21, 20); tone_cycle(23, 22);
    check("jitter_locked", locked, 1, 1);
    check("jitter_period", period, 41, 41);
    check("model_period", m_period, 41, 41);
    check("jitter_pulses", n_start * 10 + n_end, 10, 10);
    tone_cycle(23, 22);
    check("jump_end", n_end, 1, 1);
    check("jump_unlocked", locked, 0, 0);
    tone_cycle(20, 20);
    check("relock_count", n_start, 2, 2);
    check("relock_period", start_per, 45, 45);

    // Reset in the middle of a note
    pulse_reset(16'd100);
    check("midrst_no_end", n_end, 1, 1);
    check("midrst_period", period, 0, 0);
    check("midrst_silence", silence, 1, 1);
    check("midrst_locked", locked, 0, 0);
    tone_cycle(20, 20); tone_cycle(20, 20);
    check("midrst_2rises", n_start, 2, 2);
    tone_cycle(20, 20);
    check("midrst_3rises", n_start, 3, 3);
    check("midrst_latency", start_cyc - last_set, 3, 3);

    // Duration: ~500 ms locked at 20 clk/ms, then silence
    pulse_reset(16'd20);
    bs = n_start; be = n_end;
    for (int k = 0; k < 243; k++) tone_cycle(20, 20);
    check("dur_started", n_start - bs, 1, 1);
    wait_end(be, 1000);
    check("dur_end_seen", n_end - be, 1, 1);
    check("dur_at_end", end_dur, 499, 501);
    check("end_after_rise", end_cyc - (last_set + 3), 381, 402);
    repeat (50) @(negedge clk);
    check("dur_holds", dur_ms, 499, 501);
    check("dur_silence", silence, 1, 1);

    // ticks_per_milli = 0: one ms per clk
    pulse_reset(16'd0);
    bs = n_start; be = n_end;
    for (int k = 0; k < 6; k++) tone_cycle(5, 5);
    check("tpm0_locked", locked, 1, 1);
    check("tpm0_start", n_start - bs, 1, 1);
    d0 = dur_ms;
    repeat (5) @(negedge clk);
    check("tpm0_dur_rate", dur_ms - d0, 5, 5);
    wait_end(be, 100);
    check("tpm0_end_seen", n_end - be, 1, 1);
    check("tpm0_timeout", end_cyc - (last_set + 3), 20, 22);

    // Counter overflow while locked
    pulse_reset(16'hFFFF);
    bs = n_start; be = n_end;
    tone_cycle(20, 20); tone_cycle(20, 20); tone_cycle(20, 20);
    check("ovf_locked", locked, 1, 1);
    tone_cycle(20, 65580);
    tone_cycle(20, 20);
    check("ovf_end", n_end - be, 1, 1);
    check("ovf_end_latency", end_cyc - last_set, 3, 3);
    check("ovf_unlocked", locked, 0, 0);
    check("ovf_armed", silence, 0, 0);
    check("ovf_no_start", n_start - bs, 1, 1);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
